load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencing stage between the CPU execute stage and `Data_Memory`: accepts one load/store request at a time and drives `Data_Memory`'s address, write-data and write-enable. It waits out the memory's fixed read latency and returns aligned, byte-selected and extended load data to writeback. Byte stores are implemented as read-modify-write because the memory is 16-bit word-wide. While an access is in flight, `busy` stalls the core.

## Interface
Parameters:
- `RD_LAT`, default 2: cycles from `mem_addr` stable to `mem_rdata` valid. This is BRAM 1 plus output register 1. Legal values are ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_write` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_signed` in 1: byte loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 16: byte address.
- `req_wdata` in 16: store data; byte stores use `[7:0]`.
- `busy` out 1: high while an access is in flight; requests are ignored while high.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `resp_rdata` out 16: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned word access, qualified by `resp_valid`.
- `mem_we` out 1: to `Data_Memory` `MemWrite`.
- `mem_addr` out 16: word address `{1'b0, req_addr[15:1]}`, to `ALUResult`.
- `mem_wdata` out 16: to `WriteData`.
- `mem_rdata` in 16: from `ReadData`.

## Operation
- All outputs are registered.
- FSM states:
  - IDLE
  - RD_WAIT: load, or the read phase of a byte store.
  - WR: single write cycle.
  - RESP: `resp_valid` cycle, which behaves as IDLE for acceptance.
- Accept condition: `req_valid && state∈{IDLE,RESP}`. On accept, latch addr, wdata, write, byte and signed; `busy` goes high the next cycle.
- Word load: RD_WAIT for `RD_LAT` cycles, then capture `mem_rdata` into `resp_rdata`, then go to RESP.
- Byte load: same as word load.
  - Byte select: `addr[0]=0` selects `[7:0]`; `addr[0]=1` selects `[15:8]` (little-endian).
  - Extension: replicate bit 7 of the selected byte if `req_signed`, else zero-fill.
- Word store: WR, with `mem_we=1`, `mem_wdata=req_wdata`, then RESP.
- Byte store: RD_WAIT, then merge `wdata[7:0]` into the selected byte of the read word with the other byte preserved, then WR, then RESP.
- Misaligned word access (`req_byte=0`, `addr[0]=1`): no memory access and `mem_we` never asserts; go to RESP with `resp_err=1` and `resp_rdata=0`.
- `mem_addr` is held stable from the cycle after accept until the cycle after RESP, or until the next accept.
- `mem_we` is high for exactly one cycle per store.
- `busy` is 1 in RD_WAIT and WR, and 0 in IDLE and RESP. This allows back-to-back requests with no bubble.

## Timing
Request accepted in cycle 0. The response pulse arrives as follows:
- Load: cycle `RD_LAT+2`, which is 4 at the default.
- Word store: `mem_we` in cycle 1; `resp_valid` in cycle 2.
- Byte store: `mem_we` in cycle `RD_LAT+2`; `resp_valid` in cycle `RD_LAT+3`, which is 5 at the default.
- Misaligned: `resp_valid` in cycle 1.

Reset behaviour (`rst=0` sampled at an edge):
- Next cycle: state = IDLE, and `busy`, `resp_valid`, `resp_err`, `mem_we` = 0. `mem_addr`, `mem_wdata` and `resp_rdata` = 0; the wait counter is cleared.
- Reset mid-operation aborts the access. No `mem_we` and no `resp_valid` are issued for it, including a pending RMW write.
- A request present during reset is not accepted.

Other boundary conditions:
- `req_valid` while `busy=1`: ignored and not queued; the requester holds it.
- `resp_rdata` and `resp_err` hold their values until the next response.
- Address `0xFFFF` as a byte access maps to word `0x7FFF`, high byte; there is no wrap error.

## Test plan
- Reset, then word store `0x1234` at `0x0010`, then word load at `0x0010`. Required: `mem_we` pulse in cycle 1 with `mem_addr=0x0008`; load `resp_valid` in cycle 4 with `resp_rdata=0x1234`.
- Memory word holds `0x80F7`:
  - Byte load `addr[0]=0`, signed: returns `0xFFF7`.
  - Byte load `addr[0]=1`, unsigned: returns `0x0080`.
  - Byte load `addr[0]=1`, signed: returns `0xFF80`.
- Word holds `0xAABB`; byte store `0x11` to the odd address. Required: single `mem_we` in cycle 4 with `mem_wdata=0x11BB`; `resp_valid` in cycle 5; a reload returns `0x11BB`.
- Word load at `0x0003`. Required: `resp_valid` and `resp_err=1` in cycle 1, `resp_rdata=0`, no `mem_we`, and `busy` never rises.
- Store accepted in the RESP cycle of a preceding load (back-to-back). Required: no idle bubble. A `req_valid` pulse during `busy` is ignored.
- `rst=0` asserted in cycle 3 of a byte store. Required: no `mem_we`, no `resp_valid`, all outputs 0 on the next cycle, and the memory word unchanged.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Groups the request, response and Data_Memory signals of the load/store unit.
//   req_*       : one load/store request from the execute stage
//   busy        : access in flight, requests are ignored while high
//   resp_*      : completion pulse, load data and misalignment flag
//   mem_*       : Data_Memory address / write data / write enable / read data
// Modports:
//   slave  : the load_store_unit itself
//   master : the core + memory side (drives requests and mem_rdata)
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic        busy;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output busy, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  busy, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Sequences one load/store at a time against a 16-bit word-wide Data_Memory
// with a fixed read latency of RD_LAT cycles. Byte loads are lane-selected and
// sign/zero-extended; byte stores are done as read-modify-write.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : load_store_unit_if.slave (request, response and memory signals)
// All outputs come straight from registers.
module load_store_unit #(
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus
);

    localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Request fields kept for the duration of the access. Only the byte
    // lane of the address is needed: the word address lives in mem_addr_reg.
    logic        lane_reg,   lane_next;
    logic [7:0]  bdata_reg,  bdata_next;
    logic        write_reg,  write_next;
    logic        byte_reg,   byte_next;
    logic        signed_reg, signed_next;

    logic        busy_reg,       busy_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [15:0] resp_rdata_reg, resp_rdata_next;
    logic        resp_err_reg,   resp_err_next;
    logic        mem_we_reg,     mem_we_next;
    logic [15:0] mem_addr_reg,   mem_addr_next;
    logic [15:0] mem_wdata_reg,  mem_wdata_next;

    logic        accept;
    logic        misaligned;
    logic [7:0]  sel_byte;
    logic [15:0] load_value;
    logic [15:0] merged_word;

    // Store byte goes into the addressed lane, the other lane keeps the
    // freshly read memory contents.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_merge
            assign merged_word[gi*8 +: 8] = (lane_reg == 1'(gi)) ? bdata_reg
                                                                 : bus.mem_rdata[gi*8 +: 8];
        end
    endgenerate

    assign sel_byte   = lane_reg ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
    assign load_value = byte_reg ? {{8{signed_reg & sel_byte[7]}}, sel_byte}
                                 : bus.mem_rdata;

    // RESP is the completion cycle but already accepts the next request,
    // which is what makes back-to-back operation bubble-free.
    assign accept     = bus.req_valid && ((state_reg == IDLE) || (state_reg == RESP));
    assign misaligned = !bus.req_byte && bus.req_addr[0];

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        lane_next       = lane_reg;
        bdata_next      = bdata_reg;
        write_next      = write_reg;
        byte_next       = byte_reg;
        signed_next     = signed_reg;
        busy_next       = busy_reg;
        resp_valid_next = 1'b0;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;

        case (state_reg)
            IDLE, RESP: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                if (accept) begin
                    lane_next   = bus.req_addr[0];
                    bdata_next  = bus.req_wdata[7:0];
                    write_next  = bus.req_write;
                    byte_next   = bus.req_byte;
                    signed_next = bus.req_signed;
                    if (misaligned) begin
                        // Rejected without touching memory.
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = 16'h0000;
                    end else begin
                        mem_addr_next = {1'b0, bus.req_addr[15:1]};
                        busy_next     = 1'b1;
                        if (bus.req_write && !bus.req_byte) begin
                            state_next     = WR;
                            mem_we_next    = 1'b1;
                            mem_wdata_next = bus.req_wdata;
                        end else begin
                            state_next = RD_WAIT;
                            cnt_next   = '0;
                        end
                    end
                end
            end

            RD_WAIT: begin
                // mem_addr became stable on entry; read data is valid in the
                // RD_LAT-th cycle after that, i.e. when cnt reaches RD_LAT.
                if (cnt_reg == CW'(RD_LAT)) begin
                    if (write_reg) begin
                        state_next     = WR;
                        mem_we_next    = 1'b1;
                        mem_wdata_next = merged_word;
                    end else begin
                        state_next      = RESP;
                        busy_next       = 1'b0;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b0;
                        resp_rdata_next = load_value;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            WR: begin
                state_next      = RESP;
                busy_next       = 1'b0;
                resp_valid_next = 1'b1;
                resp_err_next   = 1'b0;
                resp_rdata_next = 16'h0000;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            lane_reg       <= 1'b0;
            bdata_reg      <= 8'h00;
            write_reg      <= 1'b0;
            byte_reg       <= 1'b0;
            signed_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 16'h0000;
            resp_err_reg   <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 16'h0000;
            mem_wdata_reg  <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            lane_reg       <= lane_next;
            bdata_reg      <= bdata_next;
            write_reg      <= write_next;
            byte_reg       <= byte_next;
            signed_reg     <= signed_next;
            busy_reg       <= busy_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench for load_store_unit with a Data_Memory stand-in (RD_LAT-deep
// read pipeline). A transaction-level model schedules, per accepted request,
// the cycles where busy / mem_we / resp_valid must appear and their values;
// one negedge process compares the DUT against that schedule every cycle.
module tb_load_store_unit;
    localparam int RD_LAT = 2;
    localparam int NC     = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- memory stand-in ----------------
    logic [15:0] mem [64];
    logic [15:0] rd_pipe [RD_LAT];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (bus.mem_we)
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        rd_pipe[0] <= mem[bus.mem_addr[5:0]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    bit          e_busy [NC];
    bit          e_rv   [NC];
    bit          e_err  [NC];
    bit          e_we   [NC];
    bit          e_zero [NC];
    logic [15:0] e_rdata[NC];
    logic [15:0] e_waddr[NC];
    logic [15:0] e_wdata[NC];
    int          free_cyc = 0;

    logic [15:0] shadow [int];

    int          last_we_cyc = -1, last_resp_cyc = -1, we_cnt = 0;
    logic [15:0] last_we_addr = '0, last_we_data = '0, last_resp_rdata = '0;
    logic        last_resp_err = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] shadow_rd(input int wa);
        return shadow.exists(wa) ? shadow[wa] : 16'h0000;
    endfunction

    // Transaction model: what the memory word/response must be, and when.
    task automatic model_accept(input int c, input bit wr, input bit by, input bit sg,
                                input logic [15:0] a, input logic [15:0] wd);
        int          wa   = int'(a) / 2;
        int          lane = int'(a) % 2;
        int          word;
        int          bval;
        int          val;
        word = int'(shadow_rd(wa));
        bval = (lane == 1) ? (word / 256) : (word % 256);
        if (!by && lane == 1) begin
            e_rv[c+1] = 1; e_err[c+1] = 1; e_rdata[c+1] = 16'h0000;
            free_cyc = c + 1;
        end else if (wr && !by) begin
            e_busy[c+1] = 1;
            e_we[c+1] = 1; e_waddr[c+1] = 16'(wa); e_wdata[c+1] = wd;
            e_rv[c+2] = 1; e_err[c+2] = 0; e_rdata[c+2] = 16'h0000;
            free_cyc = c + 2;
        end else if (!wr) begin
            if (!by)                     val = word;
            else if (sg && bval >= 128)  val = bval + 65280;
            else                         val = bval;
            for (int k = c + 1; k <= c + RD_LAT + 1; k++) e_busy[k] = 1;
            e_rv[c+RD_LAT+2] = 1; e_err[c+RD_LAT+2] = 0; e_rdata[c+RD_LAT+2] = 16'(val);
            free_cyc = c + RD_LAT + 2;
        end else begin
            if (lane == 1) val = (int'(wd) % 256) * 256 + (word % 256);
            else           val = (word / 256) * 256 + (int'(wd) % 256);
            for (int k = c + 1; k <= c + RD_LAT + 2; k++) e_busy[k] = 1;
            e_we[c+RD_LAT+2] = 1; e_waddr[c+RD_LAT+2] = 16'(wa); e_wdata[c+RD_LAT+2] = 16'(val);
            e_rv[c+RD_LAT+3] = 1; e_err[c+RD_LAT+3] = 0; e_rdata[c+RD_LAT+3] = 16'h0000;
            free_cyc = c + RD_LAT + 3;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            k = cyc;
            chk("busy", int'(bus.busy), int'(e_busy[k]));
            chk("resp_valid", int'(bus.resp_valid), int'(e_rv[k]));
            chk("mem_we", int'(bus.mem_we), int'(e_we[k]));
            if (e_rv[k]) begin
                chk("resp_err", int'(bus.resp_err), int'(e_err[k]));
                chk("resp_rdata", int'(bus.resp_rdata), int'(e_rdata[k]));
            end
            if (e_we[k]) begin
                chk("mem_addr", int'(bus.mem_addr), int'(e_waddr[k]));
                chk("mem_wdata", int'(bus.mem_wdata), int'(e_wdata[k]));
                shadow[int'(e_waddr[k])] = e_wdata[k];
            end
            if (e_zero[k]) begin
                chk("rst_mem_addr", int'(bus.mem_addr), 0);
                chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
                chk("rst_resp_rdata", int'(bus.resp_rdata), 0);
                chk("rst_resp_err", int'(bus.resp_err), 0);
            end
            if (bus.mem_we) begin
                last_we_cyc = k; last_we_addr = bus.mem_addr; last_we_data = bus.mem_wdata;
                we_cnt++;
            end
            if (bus.resp_valid) begin
                last_resp_cyc = k; last_resp_rdata = bus.resp_rdata; last_resp_err = bus.resp_err;
                $display("cyc %0d resp rdata=%04h err=%0d", k, bus.resp_rdata, bus.resp_err);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic preload(input int wa, input logic [15:0] v);
        pl_en = 1'b1; pl_addr = 6'(wa); pl_data = v;
        shadow[wa] = v;
        step();
        pl_en = 1'b0;
    endtask

    task automatic issue(input bit wr, input bit by, input bit sg,
                         input logic [15:0] a, input logic [15:0] wd, output int c);
        while (cyc < free_cyc) step();
        c = cyc;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_byte = by;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        model_accept(c, wr, by, sg, a, wd);
        $display("cyc %0d req wr=%0d byte=%0d signed=%0d addr=%04h wdata=%04h", c, wr, by, sg, a, wd);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic settle();
        while (cyc <= free_cyc) step();
    endtask

    task automatic do_reset();
        int n;
        n = cyc;
        rst = 1'b0;
        // A request present during reset must not be accepted.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_byte = 1'b0;
        bus.req_addr = 16'h0012; bus.req_wdata = 16'hDEAD;
        for (int k = n + 1; k < NC; k++) begin
            e_busy[k] = 0; e_rv[k] = 0; e_err[k] = 0; e_we[k] = 0; e_zero[k] = 0;
        end
        e_zero[n+1] = 1;
        step();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        free_cyc = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, c3, we0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
        step(); step();
        chk_en = 1'b1;
        do_reset();
        preload(9, 16'h0000);
        preload(10, 16'h0000);

        // Word store then word load at 0x0010.
        issue(1, 0, 0, 16'h0010, 16'h1234, c1);
        settle();
        chk("st_we_delay", last_we_cyc - c1, 1);
        chk("st_we_addr", int'(last_we_addr), 16'h0008);
        issue(0, 0, 0, 16'h0010, 16'h0000, c2);
        settle();
        chk("ld_resp_delay", last_resp_cyc - c2, 4);
        chk("ld_rdata", int'(last_resp_rdata), 16'h1234);

        // Byte loads from 0x80F7.
        preload(16'h20, 16'h80F7);
        issue(0, 1, 1, 16'h0040, 16'h0000, c1); settle();
        chk("bld_lo_signed", int'(last_resp_rdata), 16'hFFF7);
        issue(0, 1, 0, 16'h0041, 16'h0000, c1); settle();
        chk("bld_hi_unsigned", int'(last_resp_rdata), 16'h0080);
        issue(0, 1, 1, 16'h0041, 16'h0000, c1); settle();
        chk("bld_hi_signed", int'(last_resp_rdata), 16'hFF80);
        issue(0, 1, 0, 16'h0040, 16'h0000, c1); settle();
        chk("bld_lo_unsigned", int'(last_resp_rdata), 16'h00F7);

        // Byte store RMW on 0xAABB, odd lane, then even-lane store elsewhere.
        preload(16'h30, 16'hAABB);
        we0 = we_cnt;
        issue(1, 1, 0, 16'h0061, 16'h5511, c1); settle();
        chk("bst_we_delay", last_we_cyc - c1, 4);
        chk("bst_wdata", int'(last_we_data), 16'h11BB);
        chk("bst_resp_delay", last_resp_cyc - c1, 5);
        chk("bst_we_count", we_cnt - we0, 1);
        issue(0, 0, 0, 16'h0060, 16'h0000, c1); settle();
        chk("bst_reload", int'(last_resp_rdata), 16'h11BB);
        issue(1, 1, 0, 16'h0040, 16'h0099, c1); settle();
        chk("bst_even_wdata", int'(last_we_data), 16'h8099);

        // Misaligned word load.
        we0 = we_cnt;
        issue(0, 0, 0, 16'h0003, 16'h0000, c1); settle();
        chk("mis_resp_delay", last_resp_cyc - c1, 1);
        chk("mis_err", int'(last_resp_err), 1);
        chk("mis_rdata", int'(last_resp_rdata), 0);
        chk("mis_no_we", we_cnt - we0, 0);

        // Back-to-back: ignored pulse while busy, store accepted in load's RESP.
        issue(0, 0, 0, 16'h0010, 16'h0000, c1);
        step();
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_byte = 1'b0;
        bus.req_addr = 16'h0012; bus.req_wdata = 16'hDEAD;
        step();
        bus.req_valid = 1'b0;
        issue(1, 0, 0, 16'h0014, 16'hBEEF, c2);
        settle();
        chk("b2b_store_resp", last_resp_cyc - c1, 6);
        chk("b2b_ignored_word", int'(mem[9]), 16'h0000);
        chk("b2b_store_word", int'(mem[10]), 16'hBEEF);

        // Top byte address.
        preload(16'h7FFF, 16'h5A00);
        issue(0, 1, 0, 16'hFFFF, 16'h0000, c1); settle();
        chk("top_byte", int'(last_resp_rdata), 16'h005A);

        // Reset in cycle 3 of a byte store.
        preload(16'h18, 16'hCCDD);
        we0 = we_cnt;
        c3 = last_resp_cyc;
        issue(1, 1, 0, 16'h0030, 16'h0077, c1);
        step(); step();
        do_reset();
        step(); step(); step(); step();
        chk("rst_no_we", we_cnt - we0, 0);
        chk("rst_no_resp", last_resp_cyc, c3);
        chk("rst_mem_kept", int'(mem[16'h18]), 16'hCCDD);
        chk("rst_req_ignored", int'(mem[9]), 16'h0000);
        issue(0, 0, 0, 16'h0030, 16'h0000, c1); settle();
        chk("rst_reload", int'(last_resp_rdata), 16'hCCDD);

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
